// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between the requester side and the 8:1 mux round-robin scheduler.
// Master drives the requests; slave returns the mux select, enable and grant.
interface mux_rr_scheduler_if;
  logic [7:0] REQ;
  logic [2:0] S;
  logic       ENb;
  logic [7:0] GNT;
  logic       VALID;

  modport master (output REQ, input  S, ENb, GNT, VALID);
  modport slave  (input  REQ, output S, ENb, GNT, VALID);
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for an 8:1 mux.
// A select change is always followed by SETTLE cycles with the mux disabled before the grant goes live.
module mux_rr_scheduler #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic               CLK,
  input  logic               RSTb,
  mux_rr_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SWITCH, GRANT} state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);
  localparam logic [3:0] DWELL_MAX   = 4'(DWELL);

  state_t     r_state, w_state_nx;
  logic [2:0] r_s, w_s_nx;
  logic [2:0] r_ptr, w_ptr_nx;
  logic [2:0] r_settle, w_settle_nx;
  logic [3:0] r_dwell, w_dwell_nx;
  logic       r_enb, w_enb_nx;
  logic       r_valid, w_valid_nx;
  logic [7:0] r_gnt, w_gnt_nx;

  logic [2:0] w_base, w_win;
  logic       w_any, w_exit;

  // First set bit at or after base, wrapping 7 -> 0. Descending scan so the
  // smallest circular offset is the last (winning) assignment.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] base);
    logic [2:0] idx;
    rr_pick = base;
    for (int k = 7; k >= 0; k--) begin
      idx = base + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  // On grant exit the pointer moves to S+1 and arbitration uses that same edge.
  assign w_base = (r_state == GRANT) ? (r_s + 3'd1) : r_ptr;
  assign w_win  = rr_pick(bus.REQ, w_base);
  assign w_any  = |bus.REQ;
  assign w_exit = !bus.REQ[r_s] || (r_dwell == DWELL_MAX);

  always_comb begin
    w_state_nx  = r_state;
    w_s_nx      = r_s;
    w_ptr_nx    = r_ptr;
    w_settle_nx = r_settle;
    w_dwell_nx  = r_dwell;
    w_enb_nx    = r_enb;
    w_valid_nx  = r_valid;
    w_gnt_nx    = r_gnt;
    case (r_state)
      IDLE: begin
        w_enb_nx   = 1'b1;
        w_gnt_nx   = '0;
        w_valid_nx = 1'b0;
        if (w_any) begin
          w_s_nx      = w_win;
          w_settle_nx = '0;
          w_state_nx  = SWITCH;
        end
      end
      SWITCH: begin
        w_enb_nx   = 1'b1;
        w_gnt_nx   = '0;
        w_valid_nx = 1'b0;
        if (r_settle == SETTLE_LAST) begin
          w_state_nx = GRANT;
          w_enb_nx   = 1'b0;
          w_gnt_nx   = 8'b1 << r_s;
          w_valid_nx = 1'b1;
          w_dwell_nx = 4'd1;
        end else begin
          w_settle_nx = r_settle + 3'd1;
        end
      end
      GRANT: begin
        if (w_exit) begin
          w_ptr_nx = r_s + 3'd1;
          if (!w_any) begin
            w_state_nx = IDLE;
            w_enb_nx   = 1'b1;
            w_gnt_nx   = '0;
            w_valid_nx = 1'b0;
            w_dwell_nx = '0;
          end else if (w_win != r_s) begin
            w_state_nx  = SWITCH;
            w_s_nx      = w_win;
            w_settle_nx = '0;
            w_enb_nx    = 1'b1;
            w_gnt_nx    = '0;
            w_valid_nx  = 1'b0;
            w_dwell_nx  = '0;
          end else begin
            // Sole requester: keep the mux enabled, just restart the dwell window.
            w_dwell_nx = 4'd1;
          end
        end else begin
          w_dwell_nx = r_dwell + 4'd1;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_enb_nx   = 1'b1;
        w_gnt_nx   = '0;
        w_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_state  <= IDLE;
      r_s      <= '0;
      r_ptr    <= '0;
      r_settle <= '0;
      r_dwell  <= '0;
      r_enb    <= 1'b1;
      r_valid  <= 1'b0;
      r_gnt    <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_s      <= w_s_nx;
      r_ptr    <= w_ptr_nx;
      r_settle <= w_settle_nx;
      r_dwell  <= w_dwell_nx;
      r_enb    <= w_enb_nx;
      r_valid  <= w_valid_nx;
      r_gnt    <= w_gnt_nx;
    end
  end

  assign bus.S     = r_s;
  assign bus.ENb   = r_enb;
  assign bus.GNT   = r_gnt;
  assign bus.VALID = r_valid;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler (DWELL=4, SETTLE=1); inputs driven and outputs
// sampled on the falling edge, expected values worked out by hand.
module tb_mux_rr_scheduler;

  logic CLK = 1'b0;
  logic RSTb;
  int   n_tests = 0;
  int   n_fail  = 0;

  mux_rr_scheduler_if bus ();

  mux_rr_scheduler #(.DWELL(4), .SETTLE(1)) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Mux enabled with grant on owner s.
  task automatic chk_grant(input string tag, input logic [2:0] s);
    chk({tag, ".S"},     32'(bus.S),     32'(s));
    chk({tag, ".ENb"},   32'(bus.ENb),   32'd0);
    chk({tag, ".GNT"},   32'(bus.GNT),   32'(8'b1 << s));
    chk({tag, ".VALID"}, 32'(bus.VALID), 32'd1);
  endtask

  // Mux disabled (SWITCH or IDLE) with select s.
  task automatic chk_off(input string tag, input logic [2:0] s);
    chk({tag, ".S"},     32'(bus.S),     32'(s));
    chk({tag, ".ENb"},   32'(bus.ENb),   32'd1);
    chk({tag, ".GNT"},   32'(bus.GNT),   32'd0);
    chk({tag, ".VALID"}, 32'(bus.VALID), 32'd0);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    RSTb    = 1'b0;
    bus.REQ = 8'h00;
    #12;
    chk_off("reset", 3'd0);

    // Single request: select one cycle later, grant the cycle after that.
    step(); RSTb = 1'b1; bus.REQ = 8'h04;
    step(); chk_off("single.sw", 3'd2);
    step(); chk_grant("single.gnt", 3'd2);
    bus.REQ = 8'h00;
    step(); chk_off("single.idle", 3'd2);

    // All requesting from reset: 0..7 then wrap to 0, 1 SWITCH + 4 GRANT each.
    RSTb = 1'b0;
    step(); RSTb = 1'b1; bus.REQ = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step(); chk_off($sformatf("rr%0d.sw", g), 3'(g));
      for (int k = 0; k < 4; k++) begin
        step(); chk_grant($sformatf("rr%0d.g%0d", g, k), 3'(g));
      end
    end

    // Sole requester 5: no SWITCH cycles at dwell expiry.
    bus.REQ = 8'h20;
    step(); chk_off("sole.sw", 3'd5);
    for (int k = 0; k < 12; k++) begin
      step(); chk_grant($sformatf("sole.g%0d", k), 3'd5);
    end

    // 7 then wrap to 0.
    bus.REQ = 8'h81;
    step(); chk_off("wrap.sw7", 3'd7);
    for (int k = 0; k < 4; k++) begin
      step(); chk_grant($sformatf("wrap.g7_%0d", k), 3'd7);
    end
    step(); chk_off("wrap.sw0", 3'd0);
    for (int k = 0; k < 4; k++) begin
      step(); chk_grant($sformatf("wrap.g0_%0d", k), 3'd0);
    end

    // REQ[S] drops during SWITCH: one GRANT cycle, then next requester.
    step(); chk_off("drop.sw7", 3'd7);
    bus.REQ = 8'h01;
    step(); chk_grant("drop.g7", 3'd7);
    step(); chk_off("drop.sw0", 3'd0);
    bus.REQ = 8'h00;
    step(); chk_grant("drop.g0", 3'd0);
    step(); chk_off("drop.idle", 3'd0);

    // Async reset mid-grant on 3, then re-grant from PTR=0.
    bus.REQ = 8'h08;
    step(); chk_off("rst.sw3", 3'd3);
    step(); chk_grant("rst.g3", 3'd3);
    #2 RSTb = 1'b0;
    #1 chk_off("rst.async", 3'd0);
    step(); RSTb = 1'b1;
    step(); chk_off("rst.resw3", 3'd3);
    step(); chk_grant("rst.reg3", 3'd3);
    bus.REQ = 8'h00;
    step(); chk_off("rst.idle", 3'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
